branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side counterpart to taken_branch: predicts whether a conditional branch will be taken before it resolves, then learns from the resolved outcome that taken_branch produces in execute.
- Direct-mapped branch history table (BHT) of tagged 2-bit saturating counters, indexed by PC.
- Also flags mispredictions for the redirect logic and keeps branch and mispredict statistic counters for the CSR/MMIO counter block.

Parameters:
- PC_WIDTH, 32, width of the program counter.
- LINES, 8, number of BHT entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_guess  input  PC_WIDTH  PC of the instruction in fetch.
- is_br_guess  input  1  fetch-stage instruction is a conditional branch (opcode 1100011).
- taken_guess  output  1  predicted direction for pc_guess.
- pc_check  input  PC_WIDTH  PC of the branch resolving in execute.
- is_br_check  input  1  execute-stage instruction is a conditional branch and is valid (not flushed).
- pred_check  input  1  prediction originally made for this branch, piped down from fetch.
- taken_check  input  1  resolved direction, taken output of taken_branch.
- mispredict  output  1  pred_check != taken_check on a valid branch.
- br_count  output  32  number of resolved branches.
- mispred_count  output  32  number of mispredictions.

Behaviour:
- Address split: index = PC[2+IW-1:2] with IW = log2(LINES); tag = PC[PC_WIDTH-1:2+IW]. PC[1:0] is ignored.
- Each entry holds a valid bit, a tag and a 2-bit counter: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Reset (async, any time, including mid-update): all valid bits, counters and tags clear to 0; br_count and mispred_count clear to 0.
- Lookup is combinational (zero latency):
  - taken_guess = is_br_guess & valid[idx] & (tag match) & counter[1].
  - A miss or a non-branch gives taken_guess = 0.
  - With rst asserted, taken_guess = 0.
- Update happens on the rising edge when is_br_check = 1, at index/tag of pc_check:
  - Hit: if taken_check = 1, counter increments, saturating at 11; if taken_check = 0, it decrements, saturating at 00.
  - Miss (invalid entry or tag mismatch): allocate by setting valid = 1, writing the new tag, and setting counter = 10 if taken_check else 01. The previous occupant is evicted.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- mispredict = is_br_check & (pred_check ^ taken_check), combinational. It is 0 whenever is_br_check = 0 or rst = 1.
- Statistics, updated on the rising edge:
  - br_count increments by 1 when is_br_check = 1.
  - mispred_count increments by 1 when mispredict = 1.
  - Both wrap from 0xFFFFFFFF to 0 with no saturation or flag.
- Inputs with is_br_check = 0 change no state.
- No handshake: the pipeline guarantees at most one resolve per cycle. Stall and flush gating of is_br_check is the caller's responsibility.

Decomposition:
- Shared package (cpu constants): branch opcode, counter encodings SNT/WNT/WT/ST, and the default for LINES.
- One natural sub-module: sat_counter2, a 2-bit saturating counter next-state function with inputs cur and taken and output next. It is instantiated for the update path.
- Table storage stays inline as a flop array (LINES is small, and async reset is required, so no BRAM).

Test Plan:
- Reset then lookup: assert rst; pc_guess = 0x100, is_br_guess = 1 -> taken_guess = 0, br_count = 0, mispred_count = 0.
- Allocate taken: resolve pc_check = 0x100, taken_check = 1, pred_check = 0 -> mispredict = 1 that cycle. Next cycle, lookup 0x100 -> taken_guess = 1 (counter 10), mispred_count = 1, br_count = 1.
- Saturation: resolve 0x100 taken 3 more times, then not-taken once -> taken_guess stays 1 (11 -> 10). A second not-taken gives 01, and taken_guess = 0.
- Aliasing: after training 0x100 taken, lookup 0x120 (same index for LINES = 8, different tag) -> taken_guess = 0. Resolve 0x120 not-taken -> evicts, and a lookup of 0x100 now gives 0.
- Same-cycle collision: in one cycle, lookup 0x100 (counter 01) while resolving 0x100 taken -> taken_guess = 0 that cycle, 1 the next.
- Async reset mid-update: assert rst between clock edges with is_br_check = 1 -> outputs and counters are 0 immediately without waiting for clk. After release, lookup of the trained PC gives taken_guess = 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared CPU constants for the fetch-side branch predictor.
//   BR_OPCODE  : RV32 conditional-branch opcode (1100011)
//   ctr_e      : 2-bit saturating counter states SNT/WNT/WT/ST
//   LINES_DEF  : default BHT depth
package branch_predictor_pkg;

  localparam logic [6:0] BR_OPCODE = 7'b1100011;
  localparam int         LINES_DEF = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state function of a 2-bit saturating direction counter.
//   cur   : current counter value
//   taken : resolved direction (1 = step toward ST, 0 = step toward SNT)
//   next  : counter value after the update, clamped at SNT / ST
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != ST) next = cur + 2'd1;
    end else begin
      if (cur != SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped tagged BHT of 2-bit counters.
//   clk, rst       : clock, async active-high reset
//   pc_guess       : fetch PC being looked up
//   is_br_guess    : fetch instruction is a conditional branch
//   taken_guess    : combinational predicted direction for pc_guess
//   pc_check       : PC of the branch resolving in execute
//   is_br_check    : a valid branch resolves this cycle
//   pred_check     : prediction that was made for it in fetch
//   taken_check    : resolved direction
//   mispredict     : prediction disagreed with the resolved direction
//   br_count       : resolved-branch counter (wraps)
//   mispred_count  : misprediction counter (wraps)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int LINES    = LINES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_guess,
  input  logic                is_br_guess,
  output logic                taken_guess,
  input  logic [PC_WIDTH-1:0] pc_check,
  input  logic                is_br_check,
  input  logic                pred_check,
  input  logic                taken_check,
  output logic                mispredict,
  output logic [31:0]         br_count,
  output logic [31:0]         mispred_count
);

  localparam int IW = $clog2(LINES);
  localparam int TW = PC_WIDTH - 2 - IW;

  logic [LINES-1:0]         valid_q;
  logic [LINES-1:0][TW-1:0] tag_q;
  logic [LINES-1:0][1:0]    ctr_q;

  logic [IW-1:0] g_idx, c_idx;
  logic [TW-1:0] g_tag, c_tag;
  logic          c_hit;
  logic [1:0]    ctr_sat, ctr_new;

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc_guess[1:0], pc_check[1:0]};

  assign g_idx = pc_guess[2+IW-1:2];
  assign g_tag = pc_guess[PC_WIDTH-1:2+IW];
  assign c_idx = pc_check[2+IW-1:2];
  assign c_tag = pc_check[PC_WIDTH-1:2+IW];

  // Lookup reads the registered table only, so a same-cycle update to the
  // same line is seen one cycle later (no bypass).
  assign taken_guess = ~rst & is_br_guess & valid_q[g_idx] &
                       (tag_q[g_idx] == g_tag) & ctr_q[g_idx][1];

  assign mispredict = ~rst & is_br_check & (pred_check ^ taken_check);

  assign c_hit = valid_q[c_idx] & (tag_q[c_idx] == c_tag);

  sat_counter2 u_sat (
    .cur   (ctr_q[c_idx]),
    .taken (taken_check),
    .next  (ctr_sat)
  );

  // A miss evicts the occupant and starts at the weak state of the outcome.
  assign ctr_new = c_hit ? ctr_sat : (taken_check ? WT : WNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      ctr_q   <= '0;
    end else if (is_br_check) begin
      valid_q[c_idx] <= 1'b1;
      tag_q[c_idx]   <= c_tag;
      ctr_q[c_idx]   <= ctr_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (is_br_check) br_count      <= br_count + 32'd1;
      if (mispredict)  mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule
